js_button_debounce: RTL and testbench
=====================================

# js_button_debounce

Debounces and synchronizes the five joystick-board push buttons before they reach the demo/regime logic. Each raw, active-low button passes through a two-flop synchronizer and a per-channel debounce state machine. The block outputs stable active-low levels for A–D and single-cycle press pulses for all buttons. The F-button pulse `js_button_f_d` drives the regime-change input directly; that logic advances once per cycle the pulse is high, so the pulse must be exactly one cycle wide.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable synchronized samples required to accept a new level. The default is 10 ms at 25 MHz. Legal values are ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width.

Ports (one clock, `vga_clk`; reset `arst_n` is asynchronous and active-low):
- `vga_clk`  input  1  25 MHz VGA clock; all state is clocked on its rising edge.
- `arst_n`  input  1  asynchronous active-low reset.
- `btn_raw_a`  input  1  raw button A, asynchronous, 0 = pressed.
- `btn_raw_b`  input  1  raw button B, 0 = pressed.
- `btn_raw_c`  input  1  raw button C, 0 = pressed.
- `btn_raw_d`  input  1  raw button D, 0 = pressed.
- `btn_raw_f`  input  1  raw button F, 0 = pressed.
- `js_button_a`  output  1  debounced level of A, 0 = pressed.
- `js_button_b`  output  1  debounced level of B, 0 = pressed.
- `js_button_c`  output  1  debounced level of C, 0 = pressed.
- `js_button_d`  output  1  debounced level of D, 0 = pressed.
- `js_button_f_d`  output  1  one-cycle high pulse on an accepted press of F.
- `btn_press_p`  output  5  one-cycle press pulses, bit order {f,d,c,b,a}; bit 4 is identical to `js_button_f_d`.

## Operation

- Synchronizer, per channel: two flops, `s1` then `s`. Both reset to 1. Raw inputs are used nowhere else.
- Debounce FSM, per channel. Each channel has a 2-bit state, a `CNT_W`-bit counter `cnt` and a registered level `lvl`.
  - RELEASED (`lvl` = 1):
    - `s` = 0 → go to PRESS_WAIT, `cnt` ← 0.
  - PRESS_WAIT:
    - `s` = 1 → go to RELEASED (glitch rejected).
    - Otherwise, if `cnt` = `DEBOUNCE_CYCLES`−1 → go to PRESSED, `lvl` ← 0, press pulse ← 1.
    - Otherwise `cnt` ← `cnt`+1.
  - PRESSED (`lvl` = 0):
    - `s` = 1 → go to RELEASE_WAIT, `cnt` ← 0.
  - RELEASE_WAIT:
    - `s` = 0 → go to PRESSED.
    - Otherwise, if `cnt` = `DEBOUNCE_CYCLES`−1 → go to RELEASED, `lvl` ← 1. No pulse on release.
    - Otherwise `cnt` ← `cnt`+1.
- Press pulse: registered, high for exactly one cycle, cleared on the next edge unconditionally.
- Acceptance rule: a new level is accepted only after `DEBOUNCE_CYCLES`+1 consecutive identical synchronized samples. Any opposite sample restarts from the stable state.
- `cnt` never exceeds `DEBOUNCE_CYCLES`−1, so there is no wrap-around.
- Channels are fully independent. Simultaneous presses yield simultaneous pulses on their respective bits.
- Outputs: `js_button_a`..`js_button_d` are the `lvl` of their channels. F's `lvl` is internal only.

## Timing

- Reset values (asynchronous, immediate):
  - all `s1`, `s` and `lvl` = 1;
  - all states = RELEASED and all `cnt` = 0;
  - `js_button_a`..`d` = 1;
  - `js_button_f_d` = 0 and `btn_press_p` = 5'b00000.
- Latency: define edge 0 as the first edge that samples a raw 0 into `s1`, with the raw input then held.
  - Edge 1 puts the 0 into `s`.
  - Edge 2 moves the FSM to PRESS_WAIT.
  - The level and pulse outputs change on edge `DEBOUNCE_CYCLES`+2.
  - The pulse returns to 0 on edge `DEBOUNCE_CYCLES`+3.
  - Release has the same latency for the level output.
- Reset mid-operation: any WAIT progress is discarded and an active pulse is killed immediately.
- Held across reset: a button held low through reset deassertion is treated as a new press. It produces a pulse `DEBOUNCE_CYCLES`+2 edges after the first post-reset edge.
- Pulse width is exactly one `vga_clk` cycle regardless of hold duration. At most one pulse is produced per accepted press.

## Test plan

Use `DEBOUNCE_CYCLES` = 4 for all scenarios.
- Clean press, raw A: hold `btn_raw_a` = 0.
  - Required: `js_button_a` falls on edge 6 after first sampling.
  - Required: `btn_press_p` = 5'b00001 for exactly one cycle (edge 6 to 7).
  - Required: A stays 0 while held, with no further pulses.
- Bounce, raw F: apply 0 for 3 cycles, 1 for 1 cycle, 0 for 3 cycles, then 1.
  - Required: no `js_button_f_d` pulse and no state change.
  - Then hold 0 for 6 cycles → exactly one `js_button_f_d` pulse.
- Release: after A is pressed, set raw to 1.
  - Required: `js_button_a` returns to 1 on edge 6 after first sampling of the 1.
  - Required: no pulse on release.
  - A single-cycle 0 glitch during RELEASE_WAIT must restart the release count.
- Simultaneous presses: B, D and F go low on the same edge.
  - Required: `btn_press_p` = 5'b11010 for one cycle.
  - Required: `js_button_f_d` = 1 in the same cycle.
  - Required: `js_button_b` and `js_button_d` fall together.
- Reset mid-wait: assert `arst_n` = 0 two cycles into PRESS_WAIT on C.
  - Required: all outputs return to reset values immediately.
  - Release reset with raw C still low → pulse on edge 6 after the first post-reset edge.
- Long hold: hold F for 1000 cycles.
  - Required: exactly one `js_button_f_d` pulse.
  - Required: the pulse is never high for two consecutive cycles.

Source files
------------

// File: rtl/js_button_debounce.sv
// Joystick push-button conditioning: each raw active-low button is brought
// into the vga_clk domain through a two-flop synchronizer, then filtered by
// a small per-channel debounce FSM. Levels for A-D and one-cycle press
// pulses for all five buttons are produced from registers only.
module js_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       vga_clk,
  input  logic       arst_n,
  input  logic       btn_raw_a,
  input  logic       btn_raw_b,
  input  logic       btn_raw_c,
  input  logic       btn_raw_d,
  input  logic       btn_raw_f,
  output logic       js_button_a,
  output logic       js_button_b,
  output logic       js_button_c,
  output logic       js_button_d,
  output logic       js_button_f_d,
  output logic [4:0] btn_press_p
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Last count value of a wait; reaching it with one more agreeing sample
  // accepts the new level (DEBOUNCE_CYCLES+1 identical samples in total).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel order {f,d,c,b,a} matches the press pulse bus.
  logic [4:0] btn_raw;
  logic [4:0] press_vec;
  logic [3:0] lvl_vec;

  assign btn_raw = {btn_raw_f, btn_raw_d, btn_raw_c, btn_raw_b, btn_raw_a};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_chan
      logic             s1_reg;
      logic             s_reg;
      logic             lvl_reg;
      logic             pulse_reg;
      logic [CNT_W-1:0] cnt_reg;
      state_t           state_reg;

      // Two-flop synchronizer; idle (released) value is 1.
      always_ff @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) begin
          s1_reg <= 1'b1;
          s_reg  <= 1'b1;
        end else begin
          s1_reg <= btn_raw[gi];
          s_reg  <= s1_reg;
        end
      end

      // Debounce FSM: a sample that disagrees with the accepted level starts
      // a wait; a sample that agrees again aborts it back to the stable state.
      always_ff @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) begin
          state_reg <= RELEASED;
          cnt_reg   <= '0;
          lvl_reg   <= 1'b1;
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= 1'b0;
          case (state_reg)
            RELEASED: begin
              if (s_reg != lvl_reg) begin
                state_reg <= PRESS_WAIT;
                cnt_reg   <= '0;
              end
            end
            PRESS_WAIT: begin
              if (s_reg == lvl_reg) begin
                state_reg <= RELEASED;
              end else if (cnt_reg == CNT_LAST) begin
                state_reg <= PRESSED;
                lvl_reg   <= 1'b0;
                pulse_reg <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
              end
            end
            PRESSED: begin
              if (s_reg != lvl_reg) begin
                state_reg <= RELEASE_WAIT;
                cnt_reg   <= '0;
              end
            end
            RELEASE_WAIT: begin
              if (s_reg == lvl_reg) begin
                state_reg <= PRESSED;
              end else if (cnt_reg == CNT_LAST) begin
                state_reg <= RELEASED;
                lvl_reg   <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
              end
            end
            default: begin
              state_reg <= RELEASED;
            end
          endcase
        end
      end

      assign press_vec[gi] = pulse_reg;

      // Only A-D export their level; F's level stays internal.
      if (gi < 4) begin : g_lvl
        assign lvl_vec[gi] = lvl_reg;
      end
    end
  endgenerate

  assign js_button_a   = lvl_vec[0];
  assign js_button_b   = lvl_vec[1];
  assign js_button_c   = lvl_vec[2];
  assign js_button_d   = lvl_vec[3];
  assign btn_press_p   = press_vec;
  assign js_button_f_d = press_vec[4];

endmodule

// File: tb/tb_js_button_debounce.sv
// Bench for js_button_debounce with DEBOUNCE_CYCLES = 4. Stimulus pushes the
// expected output changes (cycle stamp + {d,c,b,a levels, press bus}) into a
// queue; the monitor pops one entry for every observed output change.
module tb_js_button_debounce;

  logic       vga_clk = 1'b0;
  logic       arst_n;
  logic       btn_raw_a, btn_raw_b, btn_raw_c, btn_raw_d, btn_raw_f;
  logic       js_button_a, js_button_b, js_button_c, js_button_d;
  logic       js_button_f_d;
  logic [4:0] btn_press_p;

  js_button_debounce #(.DEBOUNCE_CYCLES(4)) dut (
    .vga_clk      (vga_clk),
    .arst_n       (arst_n),
    .btn_raw_a    (btn_raw_a),
    .btn_raw_b    (btn_raw_b),
    .btn_raw_c    (btn_raw_c),
    .btn_raw_d    (btn_raw_d),
    .btn_raw_f    (btn_raw_f),
    .js_button_a  (js_button_a),
    .js_button_b  (js_button_b),
    .js_button_c  (js_button_c),
    .js_button_d  (js_button_d),
    .js_button_f_d(js_button_f_d),
    .btn_press_p  (btn_press_p)
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [8:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  base;

  task automatic push_ev(input int c, input logic [8:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  function automatic logic [8:0] outs();
    return {js_button_d, js_button_c, js_button_b, js_button_a, btn_press_p};
  endfunction

  // Monitor: compares every output change against the next queued event,
  // and checks the F pulse aliasing / single-cycle width every cycle.
  initial begin
    logic [8:0] prev;
    logic [8:0] cur;
    ev_t        e;
    prev = 9'b1111_00000;
    forever begin
      @(negedge vga_clk);
      cur = outs();
      n_checks++;
      if (js_button_f_d !== btn_press_p[4]) begin
        n_fail++;
        $display("FAIL f_alias: cyc %0d js_button_f_d=%b btn_press_p[4]=%b", cyc, js_button_f_d, btn_press_p[4]);
      end
      n_checks++;
      if (cur[4] === 1'b1 && prev[4] === 1'b1) begin
        n_fail++;
        $display("FAIL f_pulse_width: cyc %0d pulse high two cycles, got 1 expected 0", cyc);
      end
      if (cur !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: cyc %0d got %b, expected no change from %b", cyc, cur, prev);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.val || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL event: got %b at cyc %0d, expected %b at cyc %0d", cur, cyc, e.val, e.cyc);
          end else begin
            $display("event cyc %0d outs %b ok", cyc, cur);
          end
        end
      end
      prev = cur;
    end
  end

  // Stimulus
  initial begin
    arst_n    = 1'b0;
    btn_raw_a = 1'b1;
    btn_raw_b = 1'b1;
    btn_raw_c = 1'b1;
    btn_raw_d = 1'b1;
    btn_raw_f = 1'b1;
    wait_cyc(3);
    chk("reset_levels", {js_button_d, js_button_c, js_button_b, js_button_a, 5'b0}, 9'b1111_00000);
    chk("reset_press", {4'b0, btn_press_p}, 9'b0);
    chk("reset_f_d", {8'b0, js_button_f_d}, 9'b0);
    arst_n = 1'b1;
    wait_cyc(3);

    // Clean press on A: level + pulse on edge 6, pulse gone on edge 7.
    base = cyc;
    btn_raw_a = 1'b0;
    push_ev(base + 7, 9'b1110_00001);
    push_ev(base + 8, 9'b1110_00000);
    wait_cyc(20);

    // Release A with a one-cycle 0 glitch sampled on edge 3: release counts
    // again from edge 4, so the level returns on edge 10.
    base = cyc;
    btn_raw_a = 1'b1;
    push_ev(base + 11, 9'b1111_00000);
    wait_cyc(3);
    btn_raw_a = 1'b0;
    wait_cyc(1);
    btn_raw_a = 1'b1;
    wait_cyc(15);

    // Bouncy F: 0 x3, 1 x1, 0 x3 -> rejected, nothing visible.
    btn_raw_f = 1'b0;
    wait_cyc(3);
    btn_raw_f = 1'b1;
    wait_cyc(1);
    btn_raw_f = 1'b0;
    wait_cyc(3);
    btn_raw_f = 1'b1;
    wait_cyc(10);

    // F held 0 for 6 cycles -> exactly one pulse.
    base = cyc;
    btn_raw_f = 1'b0;
    push_ev(base + 7, 9'b1111_10000);
    push_ev(base + 8, 9'b1111_00000);
    wait_cyc(6);
    btn_raw_f = 1'b1;
    wait_cyc(12);

    // Simultaneous B, D, F.
    base = cyc;
    btn_raw_b = 1'b0;
    btn_raw_d = 1'b0;
    btn_raw_f = 1'b0;
    push_ev(base + 7, 9'b0101_11010);
    push_ev(base + 8, 9'b0101_00000);
    wait_cyc(10);
    base = cyc;
    btn_raw_b = 1'b1;
    btn_raw_d = 1'b1;
    btn_raw_f = 1'b1;
    push_ev(base + 7, 9'b1111_00000);
    wait_cyc(12);

    // Press A so the reset below has a visible effect.
    base = cyc;
    btn_raw_a = 1'b0;
    push_ev(base + 7, 9'b1110_00001);
    push_ev(base + 8, 9'b1110_00000);
    wait_cyc(10);

    // C low, reset two cycles into PRESS_WAIT (after edge 4).
    base = cyc;
    btn_raw_c = 1'b0;
    push_ev(base + 6, 9'b1111_00000);
    wait_cyc(5);
    #2;
    arst_n = 1'b0;
    #1;
    chk("midreset_levels", {js_button_d, js_button_c, js_button_b, js_button_a, 5'b0}, 9'b1111_00000);
    chk("midreset_press", {4'b0, btn_press_p}, 9'b0);
    chk("midreset_f_d", {8'b0, js_button_f_d}, 9'b0);
    wait_cyc(3);
    // A and C held through reset release: both are new presses.
    base = cyc;
    arst_n = 1'b1;
    push_ev(base + 7, 9'b1010_00101);
    push_ev(base + 8, 9'b1010_00000);
    wait_cyc(10);
    base = cyc;
    btn_raw_a = 1'b1;
    btn_raw_c = 1'b1;
    push_ev(base + 7, 9'b1111_00000);
    wait_cyc(12);

    // Long hold of F: one pulse only.
    base = cyc;
    btn_raw_f = 1'b0;
    push_ev(base + 7, 9'b1111_10000);
    push_ev(base + 8, 9'b1111_00000);
    wait_cyc(1000);
    btn_raw_f = 1'b1;
    wait_cyc(12);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: got %0d left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
